// File: rtl/multi_sinegen_if.sv
// multi_sinegen_if: control and sample bundle of the signal generator.
// master drives controls and reads samples; slave is the generator.
interface multi_sinegen_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int PHASE_WIDTH   = 16,
  parameter int NUM_CH        = 2
);
  logic                            en;
  logic                            clr;
  logic [PHASE_WIDTH-1:0]          incr;
  logic [NUM_CH*ADDRESS_WIDTH-1:0] offset;
  logic [1:0]                      mode;
  logic [NUM_CH*3-1:0]             atten;
  logic [NUM_CH*DATA_WIDTH-1:0]    dout;
  logic                            valid;
  logic                            wrap;

  modport master (
    output en, clr, incr, offset, mode, atten,
    input  dout, valid, wrap
  );

  modport slave (
    input  en, clr, incr, offset, mode, atten,
    output dout, valid, wrap
  );
endinterface

// File: rtl/multi_sinegen.sv
// multi_sinegen: fractional phase accumulator feeding NUM_CH channels,
// each with phase offset, shared waveform mode and per-channel shift.
module multi_sinegen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int PHASE_WIDTH   = 16,
  parameter int NUM_CH        = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  multi_sinegen_if.slave s_if
);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = PHASE_WIDTH;
  localparam int NC    = NUM_CH;
  localparam int DEPTH = 1 << AW;
  localparam int MID_I = 1 << (DW - 1);
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam real TWO_PI = 6.283185307179586;

  function automatic logic [DW-1:0] f_sine(input int idx);
    real l_v;
    l_v = real'(MID_I)
        + real'(MID_I - 1) * $sin(TWO_PI * real'(idx) / real'(DEPTH))
        + 0.5;
    return DW'($rtoi(l_v));
  endfunction

  // MSB-align an address-wide value into a sample-wide value
  function automatic logic [DW-1:0] f_align(input logic [AW-1:0] v);
    logic [AW+DW-1:0] l_ext;
    l_ext = {v, {DW{1'b0}}};
    return l_ext[AW+DW-1 -: DW];
  endfunction

  logic [DW-1:0] w_sine [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_sine
    assign w_sine[i] = f_sine(i);
  end

  logic [PW-1:0] r_acc;
  logic [PW:0]   w_sum;
  logic          w_carry;
  logic [AW-1:0] w_a;
  logic [2:0]    r_vpipe;
  logic [2:0]    r_wpipe;
  logic [NC*DW-1:0] w_dout;

  assign w_sum   = {1'b0, r_acc} + {1'b0, s_if.incr};
  assign w_carry = s_if.en & ~s_if.clr & w_sum[PW];
  assign w_a     = r_acc[PW-1 -: AW];

  // phase accumulator: clear wins over advance
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_acc <= '0;
    end else if (s_if.clr) begin
      r_acc <= '0;
    end else if (s_if.en) begin
      r_acc <= w_sum[PW-1:0];
    end
  end

  // valid and wrap ride alongside the three-stage sample path
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_vpipe <= '0;
      r_wpipe <= '0;
    end else begin
      r_vpipe <= {r_vpipe[1:0], s_if.en};
      r_wpipe <= {r_wpipe[1:0], w_carry};
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_ch
    logic [AW-1:0]        w_addr;
    logic [AW-1:0]        w_tri;
    logic [DW-1:0]        w_raw;
    logic [2:0]           w_sh;
    logic signed [DW:0]   w_diff;
    logic signed [DW:0]   w_shf;
    logic [DW-1:0]        w_res;
    logic [DW-1:0]        r_raw;
    logic [DW-1:0]        r_out;

    assign w_addr = w_a + s_if.offset[k*AW +: AW];
    assign w_tri  = w_addr[AW-1]
                  ? {~w_addr[AW-2:0], 1'b0}
                  : { w_addr[AW-2:0], 1'b0};

    // waveform select for this channel's address
    always_comb begin
      w_raw = MID;
      unique case (s_if.mode)
        2'b00: w_raw = w_sine[w_addr];
        2'b01: w_raw = w_addr[AW-1] ? '0 : '1;
        2'b10: w_raw = f_align(w_addr);
        2'b11: w_raw = f_align(w_tri);
      endcase
    end

    assign w_sh   = s_if.atten[k*3 +: 3];
    assign w_diff = $signed({1'b0, r_raw})
                  - $signed({1'b0, MID});
    assign w_shf  = w_diff >>> w_sh;
    assign w_res  = MID + w_shf[DW-1:0];

    // lookup register then attenuation register
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_raw <= MID;
        r_out <= MID;
      end else begin
        r_raw <= w_raw;
        r_out <= w_res;
      end
    end

    assign w_dout[k*DW +: DW] = r_out;
  end

  assign s_if.dout  = w_dout;
  assign s_if.valid = r_vpipe[2];
  assign s_if.wrap  = r_wpipe[2];
endmodule

// File: tb/tb_multi_sinegen.sv
// tb_multi_sinegen: directed vectors plus multi-cycle runs
// checked against hand values and a small waveform model.
module tb_multi_sinegen;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  multi_sinegen_if #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(8),
    .PHASE_WIDTH(16), .NUM_CH(2)
  ) bus ();

  multi_sinegen #(
    .ADDRESS_WIDTH(8), .DATA_WIDTH(8),
    .PHASE_WIDTH(16), .NUM_CH(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .s_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [7:0] o1;
    logic [2:0] a0;
    logic [2:0] a1;
    logic [7:0] ph;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sine_ref(input logic [7:0] a);
    real v;
    v = 128.0 + 127.0 * $sin(6.283185307179586 * real'(a) / 256.0);
    return 8'($rtoi(v + 0.5));
  endfunction

  function automatic logic [7:0] raw_ref(input logic [1:0] m,
                                         input logic [7:0] a);
    logic [6:0] lo;
    lo = a[6:0];
    case (m)
      2'd0:    return sine_ref(a);
      2'd1:    return a[7] ? 8'h00 : 8'hFF;
      2'd2:    return a;
      default: return a[7] ? {~lo, 1'b0} : {lo, 1'b0};
    endcase
  endfunction

  // reset, then free-run with en=1 and check every cycle
  task automatic run(input logic [1:0] m, input logic [15:0] inc,
                     input logic [7:0] o1, input int n);
    int unsigned acc2;
    int unsigned acc3;
    logic [7:0]  a;
    logic [15:0] e;
    rst_n = 1'b0;
    tick();
    bus.mode   = m;
    bus.incr   = inc;
    bus.offset = {o1, 8'h00};
    bus.atten  = '0;
    bus.clr    = 1'b0;
    bus.en     = 1'b1;
    rst_n      = 1'b1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t >= 2) begin
        acc2 = (32'(t - 2) * 32'(inc)) % 65536;
        a    = 8'(acc2 >> 8);
        e    = {raw_ref(m, a + o1), raw_ref(m, a)};
      end else begin
        e = 16'h8080;
      end
      chk("run dout", 32'(bus.dout), 32'(e));
      chk("run valid", 32'(bus.valid), 32'(t >= 3));
      if (t >= 3) begin
        acc3 = (32'(t - 3) * 32'(inc)) % 65536;
        chk("run wrap", 32'(bus.wrap),
            32'((acc3 + 32'(inc)) >= 65536));
      end else begin
        chk("run wrap", 32'(bus.wrap), 32'd0);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    vt[0]  = '{2'd0, 8'd64,  3'd0, 3'd0, 8'h00, 8'h80, 8'hFF};
    vt[1]  = '{2'd0, 8'd64,  3'd0, 3'd0, 8'h40, 8'hFF, 8'h80};
    vt[2]  = '{2'd0, 8'd64,  3'd0, 3'd0, 8'h80, 8'h80, 8'h01};
    vt[3]  = '{2'd0, 8'd64,  3'd0, 3'd0, 8'hC0, 8'h01, 8'h80};
    vt[4]  = '{2'd0, 8'd0,   3'd0, 3'd0, 8'h20, 8'hDA, 8'hDA};
    vt[5]  = '{2'd1, 8'd0,   3'd1, 3'd7, 8'h00, 8'hBF, 8'h80};
    vt[6]  = '{2'd1, 8'd0,   3'd1, 3'd7, 8'h80, 8'h40, 8'h7F};
    vt[7]  = '{2'd1, 8'd1,   3'd0, 3'd0, 8'h7F, 8'hFF, 8'h00};
    vt[8]  = '{2'd2, 8'h10,  3'd0, 3'd0, 8'h37, 8'h37, 8'h47};
    vt[9]  = '{2'd2, 8'h10,  3'd0, 3'd0, 8'hF8, 8'hF8, 8'h08};
    vt[10] = '{2'd3, 8'h80,  3'd0, 3'd0, 8'h37, 8'h6E, 8'h90};
    vt[11] = '{2'd3, 8'h01,  3'd0, 3'd0, 8'h7F, 8'hFE, 8'hFE};
    vt[12] = '{2'd3, 8'h40,  3'd0, 3'd0, 8'hFF, 8'h00, 8'h7E};
    vt[13] = '{2'd2, 8'hF0,  3'd2, 3'd3, 8'h00, 8'h60, 8'h8E};
    vt[14] = '{2'd0, 8'd0,   3'd4, 3'd0, 8'h40, 8'h87, 8'hFF};

    // reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.en     = 1'($urandom);
      bus.clr    = 1'($urandom);
      bus.incr   = 16'($urandom);
      bus.offset = 16'($urandom);
      bus.mode   = 2'($urandom);
      bus.atten  = 6'($urandom);
      tick();
    end
    chk("rst dout", 32'(bus.dout), 32'h8080);
    chk("rst valid", 32'(bus.valid), 32'd0);
    chk("rst wrap", 32'(bus.wrap), 32'd0);

    bus.en     = 1'b0;
    bus.clr    = 1'b0;
    bus.mode   = 2'd0;
    bus.offset = '0;
    bus.atten  = '0;
    rst_n      = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post-rst dout", 32'(bus.dout), 32'h8080);
    chk("post-rst valid", 32'(bus.valid), 32'd0);
    chk("post-rst wrap", 32'(bus.wrap), 32'd0);

    // single-phase vectors: clear, one step to phase, settle
    for (int i = 0; i < 15; i++) begin
      bus.mode   = vt[i].m;
      bus.offset = {vt[i].o1, 8'h00};
      bus.atten  = {vt[i].a1, vt[i].a0};
      bus.clr    = 1'b1;
      bus.en     = 1'b0;
      tick();
      bus.clr    = 1'b0;
      bus.en     = 1'b1;
      bus.incr   = {vt[i].ph, 8'h00};
      tick();
      bus.en     = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d dout", i), 32'(bus.dout),
          32'({vt[i].e1, vt[i].e0}));
      chk($sformatf("vec%0d valid", i), 32'(bus.valid), 32'd1);
      chk($sformatf("vec%0d wrap", i), 32'(bus.wrap), 32'd0);
    end

    run(2'd0, 16'h0100, 8'd64, 600);
    run(2'd0, 16'h0080, 8'd64, 600);
    run(2'd2, 16'h0100, 8'h10, 260);
    run(2'd3, 16'h0100, 8'h00, 260);
    run(2'd2, 16'h0000, 8'h33, 8);

    // clr with en at the carry point
    run(2'd2, 16'h0100, 8'h00, 255);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr wrap0", 32'(bus.wrap), 32'd0);
    tick();
    chk("clr inflight", 32'(bus.dout), 32'hFFFF);
    chk("clr wrap1", 32'(bus.wrap), 32'd0);
    tick();
    chk("clr zero", 32'(bus.dout), 32'h0000);
    chk("clr wrap2", 32'(bus.wrap), 32'd0);
    tick();
    chk("clr next", 32'(bus.dout), 32'h0101);
    chk("clr wrap3", 32'(bus.wrap), 32'd0);

    // en low for 10 cycles: acc holds at phase 3
    bus.en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("hold dout%0d", i), 32'(bus.dout),
          (i == 1) ? 32'h0202 : 32'h0303);
      chk($sformatf("hold valid%0d", i), 32'(bus.valid),
          32'(i < 3));
    end

    // asynchronous reset mid-run
    run(2'd0, 16'h0100, 8'd64, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst dout", 32'(bus.dout), 32'h8080);
    chk("arst valid", 32'(bus.valid), 32'd0);
    chk("arst wrap", 32'(bus.wrap), 32'd0);
    tick();
    chk("arst hold", 32'(bus.dout), 32'h8080);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
